uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// UART boot loader: receives an 8N1 byte stream carrying a little-endian word count
// followed by that many little-endian words, and writes each word to RAM.
module uart_loader #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned WORD_W       = 32;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_LEN,
        LD_LOAD,
        LD_DONE,
        LD_FAULT
    } ld_state_t;

    // Two-flop synchronizer on the asynchronous serial line
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    rx_state_t        r_rx_state;
    rx_state_t        w_rx_state_nxt;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [CNT_W-1:0] w_clk_cnt_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_cnt_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_byte_valid;
    logic             w_byte_valid_nxt;
    logic             r_frame_err;
    logic             w_frame_err_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_state   <= RX_IDLE;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_clk_cnt    <= w_clk_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    // Receiver: start bit is re-checked at mid-bit so short low glitches are dropped
    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_clk_cnt_nxt    = r_clk_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_byte_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                    w_clk_cnt_nxt  = '0;
                    w_bit_cnt_nxt  = '0;
                end
            end
            RX_START: begin
                if (r_clk_cnt == HALF_LAST) begin
                    w_clk_cnt_nxt  = '0;
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_clk_cnt == BIT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_clk_cnt == BIT_LAST) begin
                    w_clk_cnt_nxt    = '0;
                    w_rx_state_nxt   = RX_IDLE;
                    w_byte_valid_nxt = r_rx_sync;
                    w_frame_err_nxt  = !r_rx_sync;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    ld_state_t         r_ld_state;
    ld_state_t         w_ld_state_nxt;
    logic [1:0]        r_byte_cnt;
    logic [1:0]        w_byte_cnt_nxt;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_nxt;
    logic [WORD_W-1:0] w_word_asm;
    logic [WORD_W-1:0] r_count;
    logic [WORD_W-1:0] w_count_nxt;
    logic [WORD_W-1:0] r_index;
    logic [WORD_W-1:0] w_index_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [3:0]        r_be;
    logic [3:0]        w_be_nxt;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] w_addr_nxt;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] w_wdata_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;

    assign w_word_asm = {r_shift, r_word[WORD_W-1:8]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ld_state <= LD_LEN;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ld_state <= w_ld_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_word     <= w_word_nxt;
            r_count    <= w_count_nxt;
            r_index    <= w_index_nxt;
            r_we       <= w_we_nxt;
            r_be       <= w_be_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Loader: count header, then word writes; a framing error abandons any partial word
    always_comb begin
        w_ld_state_nxt = r_ld_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_word_nxt     = r_word;
        w_count_nxt    = r_count;
        w_index_nxt    = r_index;
        w_we_nxt       = 1'b0;
        w_be_nxt       = 4'b0000;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_err_nxt      = r_err;
        case (r_ld_state)
            LD_LEN: begin
                if (r_frame_err) begin
                    w_err_nxt      = 1'b1;
                    w_ld_state_nxt = LD_FAULT;
                end else if (r_byte_valid) begin
                    w_word_nxt     = w_word_asm;
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_count_nxt    = w_word_asm;
                        w_index_nxt    = '0;
                        w_ld_state_nxt = (w_word_asm == '0) ? LD_DONE : LD_LOAD;
                    end
                end
            end
            LD_LOAD: begin
                if (r_frame_err) begin
                    w_err_nxt      = 1'b1;
                    w_ld_state_nxt = LD_FAULT;
                end else if (r_byte_valid) begin
                    w_word_nxt     = w_word_asm;
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_we_nxt    = 1'b1;
                        w_be_nxt    = 4'b1111;
                        w_addr_nxt  = BASE_ADDR + {r_index[WORD_W-3:0], 2'b00};
                        w_wdata_nxt = w_word_asm;
                        w_index_nxt = r_index + 32'd1;
                        if (r_index == r_count - 32'd1) begin
                            w_ld_state_nxt = LD_DONE;
                        end
                    end
                end
            end
            LD_DONE: begin
                if (r_frame_err) begin
                    w_err_nxt = 1'b1;
                end
            end
            LD_FAULT: begin
                w_ld_state_nxt = LD_FAULT;
            end
            default: begin
                w_ld_state_nxt = LD_FAULT;
            end
        endcase
        w_busy_nxt = (w_ld_state_nxt == LD_LOAD) ||
                     ((w_ld_state_nxt == LD_LEN) && (w_byte_cnt_nxt != 2'd0));
        w_done_nxt = (r_ld_state == LD_DONE);
    end

    assign data_we_o    = r_we;
    assign data_be_o    = r_be;
    assign data_addr_o  = r_addr;
    assign data_wdata_o = r_wdata;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule

// File: tb/tb_uart_loader.sv
// Randomized scoreboard bench for uart_loader: a byte-level reference model predicts writes and flags.
module tb_uart_loader;

    localparam int unsigned CPB  = 16;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    uart_loader #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .BASE_ADDR(BASE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_we_o   (data_we_o),
        .data_be_o   (data_be_o),
        .data_addr_o (data_addr_o),
        .data_wdata_o(data_wdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_n;
    bit          m_done;
    bit          m_fault;
    bit          m_err;
    bit          done_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: the stream is a count word followed by count data words
    task automatic model_byte(input logic [7:0] b, input bit ok);
        int          n;
        int          k;
        logic [31:0] w;
        bit          last;
        if (!ok) begin
            m_err = 1'b1;
            if (!m_done) m_fault = 1'b1;
        end else if (!m_done && !m_fault) begin
            m_bytes.push_back(b);
            n = m_bytes.size();
            if (n % 4 == 0) begin
                w = {m_bytes[n-1], m_bytes[n-2], m_bytes[n-3], m_bytes[n-4]};
                if (n == 4) begin
                    m_n = w;
                    if (w == 32'd0) m_done = 1'b1;
                end else begin
                    k    = n / 4 - 2;
                    last = (32'(k + 1) == m_n);
                    q.push_back('{BASE + 32'(4 * k), w, last});
                    if (last) m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic drive_bits(input logic [7:0] b);
        rx_i = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            cyc(CPB);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        model_byte(b, ok);
        drive_bits(b);
        if (ok) begin
            rx_i = 1'b1;
            cyc(CPB);
        end else begin
            rx_i = 1'b0;
            cyc(12);
            rx_i = 1'b1;
            cyc(24);
        end
        cyc(int'($urandom_range(0, 4)));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc(2);
        m_bytes.delete();
        q.delete();
        m_n     = '0;
        m_done  = 1'b0;
        m_fault = 1'b0;
        m_err   = 1'b0;
        rst_i   = 1'b0;
        cyc(2);
    endtask

    task automatic end_check(input string tag);
        bit exp_busy;
        cyc(6);
        exp_busy = !m_done && !m_fault && (m_bytes.size() > 0);
        check({tag, ".pending_writes"}, 32'(q.size()), 32'd0);
        check({tag, ".done"}, 32'(done_o), 32'(m_done));
        check({tag, ".err"}, 32'(err_o), 32'(m_err));
        check({tag, ".busy"}, 32'(busy_o), 32'(exp_busy));
    endtask

    // Monitor: every write strobe must match the oldest predicted write
    always @(negedge clk) begin
        if (rst_i) begin
            done_pending = 1'b0;
        end else begin
            if (done_pending) begin
                check("done_after_last_write", 32'(done_o), 32'd1);
                done_pending = 1'b0;
            end
            if (data_we_o) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h expected=no_write",
                             data_addr_o, data_wdata_o);
                end else begin
                    mon_e = q.pop_front();
                    check("wr_addr", data_addr_o, mon_e.addr);
                    check("wr_data", data_wdata_o, mon_e.data);
                    check("wr_be", 32'(data_be_o), 32'hF);
                    if (mon_e.last) begin
                        check("done_low_during_last_write", 32'(done_o), 32'd0);
                        done_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] n_words;
        int          bad_pos;
        logic [31:0] w;
        rx_i  = 1'b1;
        rst_i = 1'b1;
        cyc(3);
        check("rst.we", 32'(data_we_o), 32'd0);
        check("rst.be", 32'(data_be_o), 32'd0);
        check("rst.addr", data_addr_o, BASE);
        check("rst.wdata", data_wdata_o, 32'd0);
        check("rst.busy", 32'(busy_o), 32'd0);
        check("rst.done", 32'(done_o), 32'd0);
        check("rst.err", 32'(err_o), 32'd0);
        do_reset();

        // Short low pulse on an idle line
        rx_i = 1'b0;
        cyc(4);
        rx_i = 1'b1;
        cyc(40);
        end_check("glitch");

        // Two-word load, then trailing bytes after completion
        do_reset();
        send_word(32'd2);
        check("len.busy", 32'(busy_o), 32'd1);
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        end_check("load2");
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
        end_check("after_done");
        send_byte(8'h5A, 1'b0);
        end_check("ferr_in_done");

        // Zero-length load
        do_reset();
        send_word(32'd0);
        end_check("zero_len");

        // Framing error in the middle of a word
        do_reset();
        send_word(32'd1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        end_check("ferr_load");
        send_word(32'h0BAD_F00D);
        end_check("fault_hold");

        // Reset during the stop bit of a word's last byte, then a clean reload
        do_reset();
        send_word(32'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        drive_bits(8'h44);
        rx_i = 1'b1;
        cyc(4);
        do_reset();
        cyc(20);
        end_check("rst_abort");
        send_word(32'd2);
        send_word(32'hCAFE_0001);
        send_word(32'h0000_FFFF);
        end_check("reload");

        // Randomized streams, some with an injected framing error
        for (int it = 0; it < 6; it++) begin
            do_reset();
            n_words = 32'($urandom_range(1, 3));
            bad_pos = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4 * n_words - 1)) : -1;
            send_word(n_words);
            for (int j = 0; j < int'(n_words); j++) begin
                w = $urandom;
                for (int b = 0; b < 4; b++) begin
                    if (4 * j + b == bad_pos) send_byte(w[8*b +: 8], 1'b0);
                    else send_byte(w[8*b +: 8], 1'b1);
                end
            end
            end_check($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
